// File: rtl/btn_conditioner.sv
// btn_conditioner: two-flop synchroniser plus counter-validated debounce FSM.
// Emits a clean level and single-cycle press, release and long-press pulses.
// Optional feature macro: AUTOREPEAT_EN (press_pulse auto-repeat after long press).
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter int unsigned REPEAT_CYCLES   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W  = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = ($clog2(LONG_CYCLES) > 0) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } state_t;

  logic              s1_q, s_q;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_flag_q, long_flag_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_W = ($clog2(REPEAT_CYCLES) > 0) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s_q  <= s1_q;
    end
  end

  // Next-state, counter and registered-output logic for the debounce FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
`ifdef AUTOREPEAT_EN
    rep_d       = rep_q;
`endif

    case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = '0;
        end
      end
      CONFIRM_PRESS: begin
        if (!s_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hold_d      = '0;
          long_flag_d = 1'b0;
`ifdef AUTOREPEAT_EN
          rep_d       = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s_q) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = '0;
        end
      end
      CONFIRM_RELEASE: begin
        if (s_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold timer runs while the button is accepted as down; it saturates at the
    // firing point, and the pulse is suppressed on the edge that completes a release.
    if ((state_q == PRESSED || state_q == CONFIRM_RELEASE) && !long_flag_q) begin
      if (hold_q == HOLD_LAST) begin
        if (state_d != IDLE) begin
          long_d      = 1'b1;
          long_flag_d = 1'b1;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

`ifdef AUTOREPEAT_EN
    // Repeat timer only advances in PRESSED after the long press, so it pauses
    // while a release is being confirmed.
    if (state_q == PRESSED && long_flag_q) begin
      if (rep_q == REP_LAST) begin
        press_d = 1'b1;
        rep_d   = '0;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
`ifdef AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
`ifdef AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized
// button activity compared against a run-length based reference model.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: level toggles once the synchronised input has disagreed
  // with it for D+1 consecutive samples; timers count edges since the press.
  int m_s1, m_s, m_level, m_run, m_hold, m_long_done, m_rep;
  int m_press, m_rel, m_long;

  int edge_no;
  int q_press[$];
  int q_rel[$];
  int q_long[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s = 0; m_level = 0; m_run = 0;
    m_hold = 0; m_long_done = 0; m_rep = 0;
    m_press = 0; m_rel = 0; m_long = 0;
  endtask

  task automatic model_edge(input int b);
    int pre_pressed, pre_long_done;
    if (reset) begin
      model_clear();
      return;
    end
    m_press = 0; m_rel = 0; m_long = 0;
    pre_pressed   = (m_level == 1 && m_run == 0) ? 1 : 0;
    pre_long_done = m_long_done;
`ifdef AUTOREPEAT_EN
    if (pre_pressed == 1 && pre_long_done == 1) begin
      m_rep++;
      if (m_rep == R) begin
        m_press = 1;
        m_rep = 0;
      end
    end
`endif
    if (m_s != m_level) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_run = 0;
      m_level = 1 - m_level;
      if (m_level == 1) begin
        m_press = 1;
        m_hold = 0;
        m_long_done = 0;
        m_rep = 0;
      end else begin
        m_rel = 1;
      end
    end else if (m_level == 1) begin
      m_hold++;
      if (m_long_done == 0 && m_hold == L) begin
        m_long = 1;
        m_long_done = 1;
      end
    end
    m_s  = m_s1;
    m_s1 = b;
  endtask

  task automatic check_outputs();
    check("level",   int'(level),         m_level);
    check("press",   int'(press_pulse),   m_press);
    check("release", int'(release_pulse), m_rel);
    check("long",    int'(long_pulse),    m_long);
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    model_edge(int'(b));
    #1;
    check_outputs();
    edge_no++;
    if (press_pulse)   q_press.push_back(edge_no);
    if (release_pulse) q_rel.push_back(edge_no);
    if (long_pulse)    q_long.push_back(edge_no);
  endtask

  task automatic hold(input logic b, input int n);
    for (int k = 0; k < n; k++) step(b);
  endtask

  task automatic clear_log();
    edge_no = 0;
    q_press.delete();
    q_rel.delete();
    q_long.delete();
  endtask

  // Reset raised between clock edges; outputs must clear before the next edge.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_level",   int'(level),         0);
    check("rst_press",   int'(press_pulse),   0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_long",    int'(long_pulse),    0);
    step(btn_in);
    step(btn_in);
    reset = 1'b0;
  endtask

  task automatic check_first(input string tag, input int q_size, input int first, input int exp);
    check({tag, "_count"}, q_size, 1);
    if (q_size > 0) check({tag, "_edge"}, first, exp);
  endtask

  initial begin
    int b, n;
    model_clear();
    clear_log();
    #2;
    check("init_level", int'(level), 0);
    check("init_press", int'(press_pulse), 0);
    step(1'b0);
    step(1'b0);
    reset = 1'b0;

    // Scenario 1: reset mid-operation with button held, then re-detect.
    hold(1'b1, 10);
    check("s1_pre_level", int'(level), 1);
    async_reset();
    clear_log();
    hold(1'b1, 10);
    check_first("s1_press", q_press.size(), (q_press.size() > 0) ? q_press[0] : -1, 7);

    // Scenario 2: clean press, long pulse 20 cycles after press.
    async_reset();
    btn_in = 1'b0;
    hold(1'b0, 3);
    clear_log();
    hold(1'b1, 30);
    check_first("s2_press", q_press.size(), (q_press.size() > 0) ? q_press[0] : -1, 7);
    check_first("s2_long",  q_long.size(),  (q_long.size() > 0) ? q_long[0] : -1, 27);
    check("s2_level", int'(level), 1);

    // Scenario 3: short glitch is rejected.
    async_reset();
    hold(1'b0, 3);
    clear_log();
    hold(1'b1, 2);
    hold(1'b0, 10);
    check("s3_press_count", q_press.size(), 0);
    check("s3_rel_count", q_rel.size(), 0);
    check("s3_level", int'(level), 0);

    // Scenario 4: brief dropout during a held press.
    async_reset();
    hold(1'b0, 3);
    hold(1'b1, 8);
    clear_log();
    hold(1'b0, 2);
    hold(1'b1, 6);
    check("s4_press_count", q_press.size(), 0);
    check("s4_rel_count", q_rel.size(), 0);
    check("s4_level", int'(level), 1);

    // Scenario 5: press of 10 cycles then release.
    async_reset();
    hold(1'b0, 3);
    clear_log();
    hold(1'b1, 10);
    hold(1'b0, 10);
    check_first("s5_rel", q_rel.size(), (q_rel.size() > 0) ? q_rel[0] : -1, 17);
    check("s5_long_count", q_long.size(), 0);
    check("s5_level", int'(level), 0);

    // Scenario 6: long hold, auto-repeat when enabled.
    async_reset();
    hold(1'b0, 3);
    clear_log();
    hold(1'b1, 45);
    check_first("s6_long", q_long.size(), (q_long.size() > 0) ? q_long[0] : -1, 27);
`ifdef AUTOREPEAT_EN
    check("s6_press_count", q_press.size(), 4);
    if (q_press.size() == 4) begin
      check("s6_press0", q_press[0], 7);
      check("s6_press1", q_press[1], 32);
      check("s6_press2", q_press[2], 37);
      check("s6_press3", q_press[3], 42);
    end
`else
    check_first("s6_press", q_press.size(), (q_press.size() > 0) ? q_press[0] : -1, 7);
`endif
    hold(1'b0, 10);
    check("s6_level_after", int'(level), 0);

    // Randomized activity: mixed short bursts and long holds, occasional resets.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) async_reset();
      b = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(10, 40);
      else n = $urandom_range(1, 7);
      hold(b[0], n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
